wb_mem_ctrl: RTL and testbench

Writeback and data-memory access controller for the RISC-V core. Accepts one memory/ALU instruction at a time from the execute stage and runs the data-memory request/acknowledge handshake. It then drives the writeback mux select (`MemtoReg`), the register-file write enable and destination, and the two mux data inputs (`ALU_q`, `Memoria`). It stalls the upstream pipeline while an access is outstanding and aborts accesses that exceed a timeout.

---
 rtl/wb_mem_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_wb_mem_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_ctrl.sv
// wb_mem_ctrl: data-memory handshake and writeback control for the RISC-V core.
// Takes one instruction at a time from execute, runs the mem_req/mem_ack
// handshake (with timeout abort), then drives the writeback mux and regfile
// write port for a single cycle. Every output comes straight from a register.
module wb_mem_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        RegWriteIn,
    input  logic [4:0]  RdIn,
    input  logic [31:0] ALU,
    input  logic [31:0] StoreData,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ALU_q,
    output logic [31:0] Memoria,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic [4:0]  Rd,
    output logic        stall,
    output logic        error
);

    // Last REQ cycle count value; an unacked request aborts when it is reached.
    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WB} state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic        r_is_load, w_is_load_nxt;
    logic        r_regwr, w_regwr_nxt;
    logic        r_mem_req, w_mem_req_nxt;
    logic        r_mem_we, w_mem_we_nxt;
    logic [31:0] r_mem_addr, w_mem_addr_nxt;
    logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [31:0] r_alu_q, w_alu_q_nxt;
    logic [31:0] r_memoria, w_memoria_nxt;
    logic        r_memtoreg, w_memtoreg_nxt;
    logic        r_regwrite, w_regwrite_nxt;
    logic [4:0]  r_rd, w_rd_nxt;
    logic        r_error, w_error_nxt;
    logic        r_stall, w_stall_nxt;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and next values of every registered output; pulses default low.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_is_load_nxt   = r_is_load;
        w_regwr_nxt     = r_regwr;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_alu_q_nxt     = r_alu_q;
        w_memoria_nxt   = r_memoria;
        w_rd_nxt        = r_rd;
        w_memtoreg_nxt  = 1'b0;
        w_regwrite_nxt  = 1'b0;
        w_error_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (MemRead && MemWrite) begin
                        // Load and store at once is meaningless: flag it and drop it.
                        w_error_nxt = 1'b1;
                    end else if (MemRead || MemWrite) begin
                        w_is_load_nxt   = MemRead;
                        w_regwr_nxt     = RegWriteIn;
                        w_mem_addr_nxt  = ALU;
                        w_mem_wdata_nxt = StoreData;
                        w_rd_nxt        = RdIn;
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = MemWrite;
                        w_cnt_nxt       = 8'd0;
                        w_state_nxt     = S_REQ;
                    end else if (RegWriteIn) begin
                        w_is_load_nxt  = 1'b0;
                        w_alu_q_nxt    = ALU;
                        w_rd_nxt       = RdIn;
                        w_regwrite_nxt = (RdIn != 5'd0);
                        w_state_nxt    = S_WB;
                    end
                end
            end
            S_REQ: begin
                w_cnt_nxt = r_cnt + 8'd1;
                // Ack takes priority over the timeout check in the same cycle.
                if (mem_ack) begin
                    w_mem_req_nxt = 1'b0;
                    if (r_is_load) begin
                        w_memoria_nxt = mem_rdata;
                        if (r_regwr) begin
                            w_memtoreg_nxt = 1'b1;
                            w_regwrite_nxt = (r_rd != 5'd0);
                            w_state_nxt    = S_WB;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (r_cnt == LP_LAST) begin
                    w_mem_req_nxt = 1'b0;
                    w_error_nxt   = 1'b1;
                    w_state_nxt   = S_IDLE;
                end
            end
            S_WB: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_stall_nxt = (w_state_nxt != S_IDLE);
    end

    // Datapath and output registers; reset clears all of them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= 8'd0;
            r_is_load   <= 1'b0;
            r_regwr     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_alu_q     <= 32'd0;
            r_memoria   <= 32'd0;
            r_memtoreg  <= 1'b0;
            r_regwrite  <= 1'b0;
            r_rd        <= 5'd0;
            r_error     <= 1'b0;
            r_stall     <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_is_load   <= w_is_load_nxt;
            r_regwr     <= w_regwr_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_alu_q     <= w_alu_q_nxt;
            r_memoria   <= w_memoria_nxt;
            r_memtoreg  <= w_memtoreg_nxt;
            r_regwrite  <= w_regwrite_nxt;
            r_rd        <= w_rd_nxt;
            r_error     <= w_error_nxt;
            r_stall     <= w_stall_nxt;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign ALU_q     = r_alu_q;
    assign Memoria   = r_memoria;
    assign MemtoReg  = r_memtoreg;
    assign RegWrite  = r_regwrite;
    assign Rd        = r_rd;
    assign stall     = r_stall;
    assign error     = r_error;

endmodule

// File: tb/tb_wb_mem_ctrl.sv
// Bench for wb_mem_ctrl: directed vector table, reset corner case, then random ops
// checked cycle by cycle against a transaction-level timing model.
module tb_wb_mem_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset, start, MemRead, MemWrite, RegWriteIn, mem_ack;
    logic [4:0]  RdIn;
    logic [31:0] ALU, StoreData, mem_rdata;
    logic        mem_req, mem_we, MemtoReg, RegWrite, stall, error;
    logic [31:0] mem_addr, mem_wdata, ALU_q, Memoria;
    logic [4:0]  Rd;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected values of the held outputs.
    logic [31:0] m_memoria;
    logic [4:0]  m_rd;

    typedef enum int {OP_ALU, OP_LOAD, OP_STORE, OP_ILL} op_e;
    typedef struct {
        op_e         op;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw;
        int          k;      // wait cycles before ack; >= TO means never acked
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl[9];

    wb_mem_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWriteIn(RegWriteIn), .RdIn(RdIn), .ALU(ALU), .StoreData(StoreData),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ALU_q(ALU_q), .Memoria(Memoria),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .Rd(Rd), .stall(stall), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Random instruction presented while stalled; the DUT must ignore it.
    task automatic garbage();
        start      = 1'($urandom);
        MemRead    = 1'($urandom);
        MemWrite   = 1'($urandom);
        RegWriteIn = 1'($urandom);
        RdIn       = 5'($urandom);
        ALU        = $urandom;
        StoreData  = $urandom;
        mem_rdata  = $urandom;
    endtask

    task automatic chk_zero(input string tag);
        chk1({tag, ".mem_req"}, mem_req, 1'b0);
        chk1({tag, ".mem_we"}, mem_we, 1'b0);
        chk32({tag, ".mem_addr"}, mem_addr, 32'd0);
        chk32({tag, ".mem_wdata"}, mem_wdata, 32'd0);
        chk32({tag, ".ALU_q"}, ALU_q, 32'd0);
        chk32({tag, ".Memoria"}, Memoria, 32'd0);
        chk1({tag, ".MemtoReg"}, MemtoReg, 1'b0);
        chk1({tag, ".RegWrite"}, RegWrite, 1'b0);
        chk32({tag, ".Rd"}, 32'(Rd), 32'd0);
        chk1({tag, ".stall"}, stall, 1'b0);
        chk1({tag, ".error"}, error, 1'b0);
    endtask

    task automatic chk_idle(input string tag);
        chk1({tag, ".idle.stall"}, stall, 1'b0);
        chk1({tag, ".idle.mem_req"}, mem_req, 1'b0);
        chk1({tag, ".idle.RegWrite"}, RegWrite, 1'b0);
        chk1({tag, ".idle.MemtoReg"}, MemtoReg, 1'b0);
        chk32({tag, ".idle.Memoria"}, Memoria, m_memoria);
        chk32({tag, ".idle.Rd"}, 32'(Rd), 32'(m_rd));
    endtask

    // Issue one instruction from IDLE and check every cycle until back in IDLE.
    task automatic do_op(input string tag, input vec_t v);
        bit ld, st, acked;
        ld = (v.op == OP_LOAD);
        st = (v.op == OP_STORE);
        acked = 0;
        start      = 1'b1;
        MemRead    = ld || (v.op == OP_ILL);
        MemWrite   = st || (v.op == OP_ILL);
        RegWriteIn = v.rw;
        RdIn       = v.rd;
        ALU        = v.alu;
        StoreData  = v.sd;
        mem_ack    = 1'b0;
        tick();
        case (v.op)
            OP_ILL: begin
                chk1({tag, ".ill.error"}, error, 1'b1);
                chk_idle({tag, ".ill"});
                tick();
                chk1({tag, ".ill.error_once"}, error, 1'b0);
            end
            OP_ALU: begin
                if (v.rw) begin
                    m_rd = v.rd;
                    chk1({tag, ".alu.stall"}, stall, 1'b1);
                    chk1({tag, ".alu.RegWrite"}, RegWrite, v.rd != 5'd0);
                    chk1({tag, ".alu.MemtoReg"}, MemtoReg, 1'b0);
                    chk32({tag, ".alu.ALU_q"}, ALU_q, v.alu);
                    chk32({tag, ".alu.Rd"}, 32'(Rd), 32'(v.rd));
                    chk1({tag, ".alu.mem_req"}, mem_req, 1'b0);
                    garbage();
                    tick();
                end
                chk1({tag, ".alu.error"}, error, 1'b0);
                chk_idle({tag, ".alu"});
            end
            default: begin
                m_rd = v.rd;
                for (int c = 1; c <= TO && !acked; c++) begin
                    chk1({tag, ".req.mem_req"}, mem_req, 1'b1);
                    chk1({tag, ".req.mem_we"}, mem_we, st);
                    chk32({tag, ".req.mem_addr"}, mem_addr, v.alu);
                    if (st) chk32({tag, ".req.mem_wdata"}, mem_wdata, v.sd);
                    chk1({tag, ".req.stall"}, stall, 1'b1);
                    chk1({tag, ".req.RegWrite"}, RegWrite, 1'b0);
                    chk1({tag, ".req.error"}, error, 1'b0);
                    chk32({tag, ".req.Memoria"}, Memoria, m_memoria);
                    garbage();
                    if (c == v.k + 1) begin
                        mem_ack   = 1'b1;
                        mem_rdata = v.rdata;
                        acked     = 1;
                    end
                    tick();
                    mem_ack = 1'b0;
                end
                if (acked) begin
                    if (ld) m_memoria = v.rdata;
                    chk1({tag, ".ack.error"}, error, 1'b0);
                    chk1({tag, ".ack.mem_req"}, mem_req, 1'b0);
                    if (ld && v.rw) begin
                        chk1({tag, ".wb.stall"}, stall, 1'b1);
                        chk1({tag, ".wb.MemtoReg"}, MemtoReg, 1'b1);
                        chk1({tag, ".wb.RegWrite"}, RegWrite, v.rd != 5'd0);
                        chk32({tag, ".wb.Memoria"}, Memoria, v.rdata);
                        chk32({tag, ".wb.Rd"}, 32'(Rd), 32'(v.rd));
                        garbage();
                        tick();
                    end
                    chk_idle({tag, ".done"});
                end else begin
                    chk1({tag, ".to.error"}, error, 1'b1);
                    chk_idle({tag, ".to"});
                    tick();
                    chk1({tag, ".to.error_once"}, error, 1'b0);
                    chk_idle({tag, ".to2"});
                end
            end
        endcase
    endtask

    initial begin
        vec_t v;
        tbl[0] = '{OP_ALU,   32'h12345678, 32'h0,        5'd5,  1'b1, 0, 32'h0};
        tbl[1] = '{OP_LOAD,  32'h00000040, 32'h0,        5'd3,  1'b1, 3, 32'h7FFFFFFF};
        tbl[2] = '{OP_STORE, 32'h00000080, 32'h55555555, 5'd6,  1'b1, 0, 32'h0};
        tbl[3] = '{OP_LOAD,  32'h00000100, 32'h0,        5'd7,  1'b1, 99, 32'hDEADBEEF};
        tbl[4] = '{OP_LOAD,  32'h00000104, 32'h0,        5'd9,  1'b1, TO - 1, 32'h0BADF00D};
        tbl[5] = '{OP_LOAD,  32'h00000108, 32'h0,        5'd0,  1'b1, 1, 32'hCAFEBABE};
        tbl[6] = '{OP_ILL,   32'h0000010C, 32'h0,        5'd4,  1'b1, 0, 32'h0};
        tbl[7] = '{OP_ALU,   32'hA5A5A5A5, 32'h0,        5'd8,  1'b0, 0, 32'h0};
        tbl[8] = '{OP_LOAD,  32'h00000110, 32'h0,        5'd10, 1'b0, 2, 32'h13579BDF};

        reset = 1'b1; start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; RegWriteIn = 1'b0;
        RdIn = 5'd0; ALU = 32'd0; StoreData = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        m_memoria = 32'd0; m_rd = 5'd0;
        tick(); tick();
        chk_zero("reset");
        reset = 1'b0;
        tick();

        foreach (tbl[i]) do_op($sformatf("vec%0d", i), tbl[i]);

        // Reset in the middle of a request, with a start presented during stall.
        v = '{OP_LOAD, 32'h00000200, 32'h0, 5'd12, 1'b1, 99, 32'h0};
        start = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; RegWriteIn = 1'b1; RdIn = 5'd12; ALU = v.alu;
        tick();
        chk1("rst.req_up", mem_req, 1'b1);
        tick();
        reset = 1'b1; start = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; RegWriteIn = 1'b1;
        RdIn = 5'd17; ALU = 32'hFEEDFACE;
        tick();
        chk_zero("rst.mid");
        reset = 1'b0;
        tick();
        chk_zero("rst.after");
        m_memoria = 32'd0; m_rd = 5'd0;
        do_op("rst.fresh", '{OP_ALU, 32'h0000BEEF, 32'h0, 5'd21, 1'b1, 0, 32'h0});

        // Randomized ops.
        for (int i = 0; i < 200; i++) begin
            v.op    = op_e'($urandom_range(0, 3));
            if (v.op == OP_ILL && $urandom_range(0, 3) != 0) v.op = OP_LOAD;
            v.alu   = $urandom;
            v.sd    = $urandom;
            v.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            v.rw    = ($urandom_range(0, 4) != 0);
            v.k     = $urandom_range(0, TO + 1);
            v.rdata = $urandom;
            do_op($sformatf("rnd%0d", i), v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global bound so the run can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
